alu_p: RTL and testbench

ALU_P -- requirements
Module: alu_p

---
 rtl/alu_p_pkg.sv | 25 ++
 rtl/alu_p_if.sv | 28 ++
 rtl/alu_p_mul.sv | 69 ++++++
 rtl/alu_p.sv | 141 ++++++++++++++
 tb/tb_alu_p.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_p_pkg.sv
// Shared types and constants for the alu_p ALU slice.
package alu_p_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [3:0] {
    HLT = 4'd0,
    SKZ = 4'd1,
    ADD = 4'd2,
    AND = 4'd3,
    XOR = 4'd4,
    LDA = 4'd5,
    STO = 4'd6,
    JMP = 4'd7,
    SUB = 4'd8,
    MUL = 4'd9
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_p_if.sv
// Operand/result handshake bundle for alu_p; master drives operands, slave is the ALU.
interface alu_p_if import alu_p_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  opcode_e          opcode;
  logic [WIDTH-1:0] accum;
  logic [WIDTH-1:0] data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;
  logic             err;

  modport master (
    output in_valid, opcode, accum, data, out_ready,
    input  in_ready, out_valid, out, zero, carry, err
  );

  modport slave (
    input  in_valid, opcode, accum, data, out_ready,
    output in_ready, out_valid, out, zero, carry, err
  );

endinterface

// File: rtl/alu_p_mul.sv
// Iterative shift-add multiplier: operands latched on start, one partial product per cycle.
// done is high in the last iteration cycle; product already includes that cycle's partial product.
module alu_p_mul import alu_p_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               active_q, active_d;
  logic [2*WIDTH-1:0] prod_step_s;

  assign prod_step_s = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  assign done        = active_q && (cnt_q == CNT_LAST);
  assign product     = prod_step_s;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      prod_d   = {(2*WIDTH){1'b0}};
      cnt_d    = {CW{1'b0}};
      active_d = 1'b1;
    end else if (active_q) begin
      mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      prod_d   = prod_step_s;
      cnt_d    = cnt_q + CNT_ONE;
      active_d = (cnt_q != CNT_LAST);
    end else begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      cnt_q    <= {CW{1'b0}};
      active_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_p.sv
// alu_p: handshaked ALU with registered result and zero/carry/err flags.
// Build option ALU_P_MUL_EN enables the multi-cycle MUL opcode; otherwise opcode 9 is illegal.
module alu_p import alu_p_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  alu_p_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;

  logic             in_ready_s;
  logic             accept_s;
  logic             is_mul_s;
  logic [WIDTH-1:0] op_res_s;
  logic             op_carry_s;
  logic             op_err_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  assign in_ready_s = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  // Extra top bit of the difference is the borrow.
  assign sum_s  = {1'b0, bus.accum} + {1'b0, bus.data};
  assign diff_s = {1'b0, bus.accum} - {1'b0, bus.data};

  always_comb begin
    op_res_s   = bus.accum;
    op_carry_s = 1'b0;
    op_err_s   = 1'b0;
    is_mul_s   = 1'b0;
    case (bus.opcode)
      HLT, SKZ, STO, JMP: op_res_s = bus.accum;
      ADD: begin
        op_res_s   = sum_s[WIDTH-1:0];
        op_carry_s = sum_s[WIDTH];
      end
      AND: op_res_s = bus.data & bus.accum;
      XOR: op_res_s = bus.data ^ bus.accum;
      LDA: op_res_s = bus.data;
      SUB: begin
        op_res_s   = diff_s[WIDTH-1:0];
        op_carry_s = diff_s[WIDTH];
      end
`ifdef ALU_P_MUL_EN
      MUL: is_mul_s = 1'b1;
`endif
      default: op_err_s = 1'b1;
    endcase
  end

`ifdef ALU_P_MUL_EN
  logic mul_start_s;
  assign mul_start_s = accept_s && is_mul_s;

  alu_p_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_s),
    .a       (bus.accum),
    .b       (bus.data),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );
`else
  assign mul_done_s = 1'b0;
  assign mul_prod_s = {(2*WIDTH){1'b0}};
`endif

  // Result registers load only on entry to DONE, so they hold while the consumer stalls.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          if (is_mul_s) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            out_d   = op_res_s;
            zero_d  = (op_res_s == {WIDTH{1'b0}});
            carry_d = op_carry_s;
            err_d   = op_err_s;
          end
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      BUSY: begin
        if (mul_done_s) begin
          state_d = DONE;
          out_d   = mul_prod_s[WIDTH-1:0];
          zero_d  = (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
          carry_d = |mul_prod_s[2*WIDTH-1:WIDTH];
          err_d   = 1'b0;
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= {WIDTH{1'b0}};
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_p.sv
// Bench for alu_p (WIDTH=8): scoreboard of model results plus directed latency/hold/reset checks.
// Honours ALU_P_MUL_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_p;
  import alu_p_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  alu_p_if #(.WIDTH(W)) bus ();

  alu_p #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] d);
    exp_t r;
    int   t;
    r.res = a;
    r.c   = 1'b0;
    r.e   = 1'b0;
    case (op)
      4'd0, 4'd1, 4'd6, 4'd7: r.res = a;
      4'd2: begin
        t = int'(a) + int'(d);
        r.res = t[W-1:0];
        r.c   = (t > 255);
      end
      4'd3: r.res = a & d;
      4'd4: r.res = a ^ d;
      4'd5: r.res = d;
      4'd8: begin
        t = int'(a) - int'(d);
        r.res = t[W-1:0];
        r.c   = (a < d);
      end
`ifdef ALU_P_MUL_EN
      4'd9: begin
        t = int'(a) * int'(d);
        r.res = t[W-1:0];
        r.c   = (t > 255);
      end
`endif
      default: r.e = 1'b1;
    endcase
    r.z = (r.res == 8'h00);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] d);
    bit accepted = 1'b0;
    bus.in_valid = 1'b1;
    bus.opcode   = opcode_e'(op);
    bus.accum    = a;
    bus.data     = d;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb_q.push_back(model(op, a, d));
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check_eq("accept", 32'(accepted), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // Output side of the scoreboard: a result leaves when out_valid && out_ready.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check_eq("sb_out",   32'(bus.out),   32'(mon_e.res));
        check_eq("sb_zero",  32'(bus.zero),  32'(mon_e.z));
        check_eq("sb_carry", 32'(bus.carry), 32'(mon_e.c));
        check_eq("sb_err",   32'(bus.err),   32'(mon_e.e));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.opcode    = HLT;
    bus.accum     = 8'h00;
    bus.data      = 8'h00;
    bus.out_ready = 1'b1;
    tick(2);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out",       32'(bus.out),       32'd0);
    check_eq("rst_zero",      32'(bus.zero),      32'd0);
    check_eq("rst_carry",     32'(bus.carry),     32'd0);
    check_eq("rst_err",       32'(bus.err),       32'd0);
    rst = 1'b0;
    check_eq("rel_in_ready",  32'(bus.in_ready),  32'd1);

    // ADD with carry out, single-cycle latency
    send(4'd2, 8'hF0, 8'h20);
    check_eq("add_lat",   32'(bus.out_valid), 32'd1);
    check_eq("add_out",   32'(bus.out),       32'h10);
    check_eq("add_carry", 32'(bus.carry),     32'd1);
    check_eq("add_zero",  32'(bus.zero),      32'd0);

    // SUB: equal operands then borrow, issued back to back
    send(4'd8, 8'h05, 8'h05);
    check_eq("sub0_out",   32'(bus.out),   32'h00);
    check_eq("sub0_zero",  32'(bus.zero),  32'd1);
    check_eq("sub0_carry", 32'(bus.carry), 32'd0);
    send(4'd8, 8'h03, 8'h04);
    check_eq("subb_out",   32'(bus.out),   32'hFF);
    check_eq("subb_carry", 32'(bus.carry), 32'd1);

    // Illegal opcode
    send(4'hC, 8'h00, 8'h5A);
    check_eq("ill_out",  32'(bus.out),  32'h00);
    check_eq("ill_err",  32'(bus.err),  32'd1);
    check_eq("ill_zero", 32'(bus.zero), 32'd1);
`ifndef ALU_P_MUL_EN
    send(4'd9, 8'h3C, 8'h02);
    check_eq("op9_lat", 32'(bus.out_valid), 32'd1);
    check_eq("op9_err", 32'(bus.err),       32'd1);
    check_eq("op9_out", 32'(bus.out),       32'h3C);
`endif
    tick(1);

    // Consumer stall: result holds, no accept, then back-to-back accept on release
    bus.out_ready = 1'b0;
    send(4'd4, 8'hAA, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_out",       32'(bus.out),       32'h55);
      check_eq("hold_valid",     32'(bus.out_valid), 32'd1);
      check_eq("hold_in_ready",  32'(bus.in_ready),  32'd0);
      tick(1);
    end
    bus.out_ready = 1'b1;
    send(4'd5, 8'h00, 8'h07);
    check_eq("b2b_out", 32'(bus.out), 32'h07);
    tick(1);

    // Reset while a result waits in DONE discards it
    bus.out_ready = 1'b0;
    send(4'd3, 8'hF0, 8'h3C);
    rst = 1'b1;
    #1;
    check_eq("rstd_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rstd_out",   32'(bus.out),       32'd0);
    sb_q.delete();
    tick(1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("rstd_in_ready", 32'(bus.in_ready), 32'd1);
    tick(2);
    check_eq("rstd_no_result", 32'(bus.out_valid), 32'd0);

`ifdef ALU_P_MUL_EN
    // MUL: BUSY for W cycles with operands wiggling underneath
    send(4'd9, 8'h10, 8'h11);
    for (int i = 0; i < W; i++) begin
      check_eq("mul_in_ready",  32'(bus.in_ready),  32'd0);
      check_eq("mul_out_valid", 32'(bus.out_valid), 32'd0);
      bus.accum = 8'($urandom);
      bus.data  = 8'($urandom);
      tick(1);
    end
    check_eq("mul_valid", 32'(bus.out_valid), 32'd1);
    check_eq("mul_out",   32'(bus.out),       32'h10);
    check_eq("mul_carry", 32'(bus.carry),     32'd1);
    tick(1);

    // Reset in cycle 4 of a MUL aborts it
    send(4'd9, 8'h0F, 8'h0F);
    tick(3);
    rst = 1'b1;
    sb_q.delete();
    tick(1);
    rst = 1'b0;
    check_eq("rstm_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < W + 2; i++) begin
      check_eq("rstm_no_result", 32'(bus.out_valid), 32'd0);
      tick(1);
    end
`endif
    send(4'd2, 8'h01, 8'h01);
    check_eq("post_rst_add", 32'(bus.out), 32'h02);

    // Random mix of opcodes and consumer stalls
    for (int n = 0; n < 40; n++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      tick($urandom_range(0, 2));
      bus.out_ready = 1'b1;
      send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end

    bus.out_ready = 1'b1;
    tick(W + 4);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
